gpr_file_mp: RTL

- Parametrised general-purpose register file for the x86 core; successor to the single-write, two-read GPR file.
- Adds: configurable read/write port counts, per-port 8/16-bit mode, and byte-lane-merged write-first forwarding into registered read data.
- Adds a per-port read enable that holds read data.
- Sits between decode/microcode and the ALU, feeding operand and address-generation paths.

---
 rtl/gpr_file_mp.sv | 87 ++++++++
 1 files changed

// File: rtl/gpr_file_mp.sv
// gpr_file_mp: multi-port x86 GPR file with byte-lane write merging and write-first registered reads.
// Optional busy scoreboard is built when RF_SCOREBOARD_EN is defined.
module gpr_file_mp #(
    parameter int NUM_RD_PORTS = 3,
    parameter int NUM_WR_PORTS = 2,
    parameter int NUM_REGS = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             reset,
`ifdef RF_SCOREBOARD_EN
    output logic             busy        [NUM_REGS],
    input  logic [SEL_W-1:0] reserve_sel,
    input  logic             reserve_en,
`endif
    input  logic [SEL_W-1:0] rd_sel      [NUM_RD_PORTS],
    input  logic             rd_8_bit    [NUM_RD_PORTS],
    input  logic             rd_en       [NUM_RD_PORTS],
    output logic [15:0]      rd_val      [NUM_RD_PORTS],
    input  logic [SEL_W-1:0] wr_sel      [NUM_WR_PORTS],
    input  logic             wr_8_bit    [NUM_WR_PORTS],
    input  logic [15:0]      wr_val      [NUM_WR_PORTS],
    input  logic             wr_en       [NUM_WR_PORTS]
);
    logic [15:0]      regs   [NUM_REGS];
    logic [15:0]      nxt    [NUM_REGS];
    logic [SEL_W-1:0] w_idx  [NUM_WR_PORTS];
    logic [1:0]       w_lane [NUM_WR_PORTS];
    logic [15:0]      w_data [NUM_WR_PORTS];
    logic [15:0]      rd_data[NUM_RD_PORTS];

    // 8-bit encoding: sel[1:0] picks the register, sel[2] picks the high byte
    for (genvar p = 0; p < NUM_WR_PORTS; p++) begin : g_wr
        assign w_idx[p]  = wr_8_bit[p] ? SEL_W'(wr_sel[p][1:0]) : wr_sel[p];
        assign w_lane[p] = wr_8_bit[p] ? (wr_sel[p][2] ? 2'b10 : 2'b01) : 2'b11;
        assign w_data[p] = wr_8_bit[p] ? {2{wr_val[p][7:0]}} : wr_val[p];
    end

    // ascending port order lets the highest-index writer own each lane
    always_comb begin
        nxt = regs;
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            if (wr_en[p] && w_lane[p][0]) nxt[w_idx[p]][7:0] = w_data[p][7:0];
            if (wr_en[p] && w_lane[p][1]) nxt[w_idx[p]][15:8] = w_data[p][15:8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
        else
            regs <= nxt;
    end

    // reads see post-write contents, giving write-first forwarding
    for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_rd
        logic [15:0] word;
        assign word = nxt[rd_8_bit[i] ? SEL_W'(rd_sel[i][1:0]) : rd_sel[i]];
        assign rd_data[i] = rd_8_bit[i] ? {8'h00, rd_sel[i][2] ? word[15:8] : word[7:0]} : word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            for (int i = 0; i < NUM_RD_PORTS; i++) rd_val[i] <= '0;
        else
            for (int i = 0; i < NUM_RD_PORTS; i++) if (rd_en[i]) rd_val[i] <= rd_data[i];
    end

`ifdef RF_SCOREBOARD_EN
    logic [NUM_REGS-1:0] hit;
    always_comb begin
        hit = '0;
        for (int p = 0; p < NUM_WR_PORTS; p++)
            for (int r = 0; r < NUM_REGS; r++)
                if (wr_en[p] && w_idx[p] == SEL_W'(r)) hit[r] = 1'b1;
    end

    // a same-edge reserve overrides the clear from a write
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            for (int r = 0; r < NUM_REGS; r++) busy[r] <= 1'b0;
        else
            for (int r = 0; r < NUM_REGS; r++)
                busy[r] <= (reserve_en && reserve_sel == SEL_W'(r)) || (busy[r] && !hit[r]);
    end
`endif
endmodule
